dmem_bus: RTL and testbench

Data-side memory subsystem attached directly to the core's data memory ports (r_en/r_addr/r_data, w_en/w_addr/w_data); it consumes every LOAD/STORE the core issues.
- Contains a word-addressed data RAM, an MMIO register block, and a TX byte FIFO. The FIFO streams console output to a downstream UART.
- Counts retired instructions using the core's cycle_end strobe.
- Reports access faults to the debug interface.

---
 rtl/dmem_pkg.sv | 46 ++++
 rtl/dmem_tx_fifo.sv | 60 ++++++
 rtl/dmem_bus.sv | 191 +++++++++++++++++++
 tb/tb_dmem_bus.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-side memory subsystem.
//   - MMIO register offsets within the 16-byte MMIO window
//   - TX_STATUS bit positions
//   - address region decode enum and helper functions
package dmem_pkg;

  localparam logic [3:0] OFF_TX_DATA   = 4'h0;
  localparam logic [3:0] OFF_TX_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLE_CNT = 4'h8;
  localparam logic [3:0] OFF_ERR_ADDR  = 4'hC;

  // TX_STATUS bit positions
  localparam int unsigned ST_TX_VALID = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_FULL     = 2;
  localparam int unsigned ST_OVERFLOW = 3;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

  // RAM occupies [0, ram_bytes); MMIO occupies [mmio_base, mmio_base+16).
  // An address below mmio_base wraps to a huge offset and falls out of the window.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [32:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    logic [31:0] off;
    region_e     reg_sel;
    off = addr - mmio_base;
    if ({1'b0, addr} < ram_bytes)  reg_sel = REG_RAM;
    else if (off < 32'd16)         reg_sel = REG_MMIO;
    else                           reg_sel = REG_UNMAPPED;
    return reg_sel;
  endfunction

  // Word-aligned register offset inside the MMIO window (low two bits dropped).
  function automatic logic [3:0] mmio_word(input logic [31:0] addr,
                                           input logic [31:0] mmio_base);
    logic [31:0] off;
    off = addr - mmio_base;
    return {off[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_tx_fifo.sv
// dmem_tx_fifo: circular byte FIFO feeding the console UART.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (discards all entries)
//   push, push_data write one byte; accepted when not full, or when full but
//                   a pop happens in the same cycle
//   pop             remove head; ignored when empty
//   head, valid     current head byte (0 when empty) and non-empty flag
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dmem_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = !empty;
  assign head  = valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // still lands when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dmem_bus.sv
// dmem_bus: data-side memory subsystem on the core's data memory ports.
// Contains a word-addressed data RAM, a 16-byte MMIO register window, a TX
// byte FIFO towards the console UART, a retired-instruction counter and a
// sticky access-fault flag.
// Parameters: RAM_WORDS (RAM depth in words, power of two), MMIO_BASE,
//             FIFO_DEPTH (power of two, >=2).
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   r_en, r_addr, r_data     read: r_data registered, 1-cycle latency, holds when r_en=0
//   w_en, w_addr, w_data     write: commits once, on the rising edge of w_en
//   cycle_end                one pulse per retired instruction
//   tx_valid, tx_data        FIFO head towards the UART
//   tx_ready                 UART accepts the head
//   err                      sticky access-fault flag
// Build option: define DMEM_ALIGN_CHECK_EN to fault any access with
// addr[1:0] != 0; otherwise the low two address bits are ignored.
// Handshake: tx_valid/tx_data depend only on FIFO state; a byte transfers on
// every clock edge where tx_valid && tx_ready, and tx_valid never waits for
// tx_ready.
module dmem_bus
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_en,
  input  logic [31:0] r_addr,
  output logic [31:0] r_data,
  input  logic        w_en,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  input  logic        cycle_end,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err
);

  localparam int unsigned RAW       = $clog2(RAM_WORDS);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  logic [31:0]    ram [RAM_WORDS];
  logic           w_en_q;
  logic           overflow;
  logic [31:0]    cycle_cnt;
  logic [31:0]    err_addr;

  region_e        r_region;
  region_e        w_region;
  logic [3:0]     r_word;
  logic [3:0]     w_word;
  logic           r_misalign;
  logic           w_misalign;
  logic           r_fault;
  logic           w_fault;
  logic           w_commit;
  logic           w_act;
  logic           ram_we;
  logic           mmio_we;
  logic           tx_push;
  logic           ovf_clr;
  logic           cnt_wr;
  logic           err_clr;
  logic           any_fault;
  logic [31:0]    fault_addr;
  logic [31:0]    rd_word;
  logic [31:0]    tx_status;

  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_drop;
  logic [CW-1:0]  fifo_count;

  // ---------------- address decode ----------------
  assign r_region = decode_region(r_addr, RAM_BYTES, MMIO_BASE);
  assign w_region = decode_region(w_addr, RAM_BYTES, MMIO_BASE);
  assign r_word   = mmio_word(r_addr, MMIO_BASE);
  assign w_word   = mmio_word(w_addr, MMIO_BASE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign r_misalign = (r_addr[1:0] != 2'b00);
  assign w_misalign = (w_addr[1:0] != 2'b00);
`else
  assign r_misalign = 1'b0;
  assign w_misalign = 1'b0;
`endif

  assign r_fault = (r_region == REG_UNMAPPED) || r_misalign;
  assign w_fault = (w_region == REG_UNMAPPED) || w_misalign;

  // The core holds w_en for several clocks; only its rising edge acts.
  assign w_commit = w_en && !w_en_q;
  assign w_act    = w_commit && !w_fault;
  assign ram_we   = w_act && (w_region == REG_RAM);
  assign mmio_we  = w_act && (w_region == REG_MMIO);
  assign tx_push  = mmio_we && (w_word == OFF_TX_DATA);
  assign ovf_clr  = mmio_we && (w_word == OFF_TX_STATUS);
  assign cnt_wr   = mmio_we && (w_word == OFF_CYCLE_CNT);
  assign err_clr  = mmio_we && (w_word == OFF_ERR_ADDR);

  // A faulting read takes precedence over a faulting write for err_addr.
  assign any_fault  = (r_en && r_fault) || (w_commit && w_fault);
  assign fault_addr = (r_en && r_fault) ? r_addr : w_addr;

  // ---------------- TX FIFO ----------------
  dmem_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (w_data[7:0]),
    .pop       (tx_ready && !fifo_empty),
    .head      (tx_data),
    .valid     (tx_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // When full the head is valid, so a pop happens exactly when tx_ready is high.
  assign fifo_drop = tx_push && fifo_full && !tx_ready;

  always_comb begin
    tx_status              = '0;
    tx_status[ST_TX_VALID] = tx_valid;
    tx_status[ST_EMPTY]    = (fifo_count == '0);
    tx_status[ST_FULL]     = (fifo_count == CW'(FIFO_DEPTH));
    tx_status[ST_OVERFLOW] = overflow;
  end

  // ---------------- read data mux ----------------
  always_comb begin
    rd_word = '0;
    case (r_region)
      REG_RAM: rd_word = ram[r_addr[RAW+1:2]];
      REG_MMIO: begin
        case (r_word)
          OFF_TX_STATUS: rd_word = tx_status;
          OFF_CYCLE_CNT: rd_word = cycle_cnt;
          OFF_ERR_ADDR:  rd_word = err_addr;
          default:       rd_word = '0;
        endcase
      end
      default: rd_word = '0;
    endcase
  end

  // ---------------- RAM (contents not reset) ----------------
  // The registered read below samples the pre-edge contents, so a same-cycle
  // read and write of one word returns the old data.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) ram[w_addr[RAW+1:2]] <= w_data;
  end

  // ---------------- control / MMIO state ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      w_en_q    <= 1'b0;
      overflow  <= 1'b0;
      cycle_cnt <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      w_en_q <= w_en;

      if (r_en) r_data <= r_fault ? 32'h0 : rd_word;

      if (cnt_wr)         cycle_cnt <= w_data;
      else if (cycle_end) cycle_cnt <= cycle_cnt + 32'd1;

      if (fifo_drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      // First fault wins, but a clear in the same cycle yields to the new fault.
      if (any_fault) begin
        err <= 1'b1;
        if (!err || err_clr) err_addr <= fault_addr;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus.sv
// tb_dmem_bus: directed test plan plus randomized traffic for dmem_bus,
// checked every cycle against a behavioural model (array RAM, byte queue FIFO).
module tb_dmem_bus;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
  localparam int unsigned FIFO_DEPTH = 8;

  localparam logic [31:0] A_TX_DATA   = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_TX_STATUS = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_CYCLE_CNT = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_ERR_ADDR  = MMIO_BASE + 32'hC;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_en;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        cycle_end;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        err;

  always #5 clk = ~clk;

  dmem_bus #(
    .RAM_WORDS  (RAM_WORDS),
    .MMIO_BASE  (MMIO_BASE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_en      (r_en),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .cycle_end (cycle_end),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .err       (err)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  logic [31:0] m_ram   [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  logic [7:0]  exp_q[$];
  logic [31:0] m_rdata;
  bit          m_rknown;
  bit          m_ovf;
  logic [31:0] m_cnt;
  bit          m_err;
  logic [31:0] m_eaddr;
  bit          m_wprev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // 0 = RAM, 1 = MMIO, 2 = unmapped
  function automatic int region_of(input logic [31:0] a);
    if (a < RAM_WORDS * 4) return 0;
    if (a >= MMIO_BASE && (a - MMIO_BASE) < 32'd16) return 1;
    return 2;
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    bit f;
    f = (region_of(a) == 2);
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) f = 1'b1;
`endif
    return f;
  endfunction

  function automatic int reg_of(input logic [31:0] a);
    return int'(((a - MMIO_BASE) >> 2) & 32'd3);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % RAM_WORDS);
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(m_ovf) * 8 + 32'(exp_q.size() == FIFO_DEPTH) * 4
      + 32'(exp_q.size() == 0) * 2 + 32'(exp_q.size() != 0);
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit wc, rf, wf, wok, pop, drop, clr;
    int wr;
    if (!rst_n) begin
      m_rdata  = 32'h0;
      m_rknown = 1'b1;
      exp_q.delete();
      m_ovf    = 1'b0;
      m_cnt    = 32'h0;
      m_err    = 1'b0;
      m_eaddr  = 32'h0;
      m_wprev  = 1'b0;
      return;
    end
    wc  = w_en && !m_wprev;
    rf  = r_en && is_fault(r_addr);
    wf  = wc && is_fault(w_addr);
    wok = wc && !wf;
    wr  = (wok && region_of(w_addr) == 1) ? reg_of(w_addr) : -1;

    // read uses the pre-edge state
    if (r_en) begin
      m_rknown = 1'b1;
      if (rf) m_rdata = 32'h0;
      else if (region_of(r_addr) == 0) begin
        m_rdata  = m_ram[idx_of(r_addr)];
        m_rknown = m_known[idx_of(r_addr)];
      end else begin
        case (reg_of(r_addr))
          1:       m_rdata = model_status();
          2:       m_rdata = m_cnt;
          3:       m_rdata = m_eaddr;
          default: m_rdata = 32'h0;
        endcase
      end
    end

    if (wok && region_of(w_addr) == 0) begin
      m_ram[idx_of(w_addr)]   = w_data;
      m_known[idx_of(w_addr)] = 1'b1;
    end

    pop  = tx_ready && exp_q.size() != 0;
    drop = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (wr == 0) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(w_data[7:0]);
      else drop = 1'b1;
    end
    if (drop)         m_ovf = 1'b1;
    else if (wr == 1) m_ovf = 1'b0;

    if (wr == 2)        m_cnt = w_data;
    else if (cycle_end) m_cnt = m_cnt + 32'd1;

    clr = (wr == 3);
    if (rf || wf) begin
      if (!m_err || clr) m_eaddr = rf ? r_addr : w_addr;
      m_err = 1'b1;
    end else if (clr) begin
      m_err   = 1'b0;
      m_eaddr = 32'h0;
    end

    m_wprev = w_en;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      if (m_rknown) check("r_data", r_data, m_rdata);
      check("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
      check("tx_data", 32'(tx_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
      check("err", 32'(err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // w_data changes on the second held cycle; only the first value may land.
  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    w_addr = a;
    w_data = d;
    w_en   = 1'b1;
    tick();
    w_data = ~d;
    tick();
    w_en = 1'b0;
    tick();
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
    r_addr = a;
    r_en   = 1'b1;
    tick();
    v = r_data;
    tick();
    r_en = 1'b0;
  endtask

  task automatic pulse_cycle_end();
    cycle_end = 1'b1;
    tick();
    cycle_end = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      6, 7: a = MMIO_BASE + (32'($urandom_range(0, 3)) << 2);
      8: begin
        case ($urandom_range(0, 3))
          0:       a = 32'h4000_0000 + (32'($urandom_range(0, 15)) << 2);
          1:       a = MMIO_BASE + 32'h10;
          2:       a = 32'(RAM_WORDS * 4);
          default: a = MMIO_BASE - 32'd4;
        endcase
      end
      9:       a = 32'(RAM_WORDS * 4 - 4);
      default: a = 32'($urandom_range(0, 31)) << 2;
    endcase
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] v;

  initial begin
    rst_n     = 1'b0;
    r_en      = 1'b0;
    r_addr    = '0;
    w_en      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    cycle_end = 1'b0;
    tx_ready  = 1'b0;
    tick();
    tick();
    chk_on = 1'b1;
    check("reset r_data", r_data, 32'h0);
    check("reset tx_valid", 32'(tx_valid), 32'h0);
    check("reset tx_data", 32'(tx_data), 32'h0);
    check("reset err", 32'(err), 32'h0);
    rst_n = 1'b1;
    tick();

    // single write despite w_en held two clocks
    write_reg(32'h10, 32'hDEAD_BEEF);
    read_reg(32'h10, v);
    check("ram rd 0x10", v, 32'hDEAD_BEEF);
    check("model rd 0x10", m_rdata, 32'hDEAD_BEEF);

    // cycle counter, write-vs-increment priority and wrap
    repeat (5) pulse_cycle_end();
    read_reg(A_CYCLE_CNT, v);
    check("cycle_cnt 5", v, 32'd5);
    w_addr    = A_CYCLE_CNT;
    w_data    = 32'hFFFF_FFFF;
    w_en      = 1'b1;
    cycle_end = 1'b1;
    tick();
    cycle_end = 1'b0;
    tick();
    w_en = 1'b0;
    tick();
    read_reg(A_CYCLE_CNT, v);
    check("cycle_cnt write wins", v, 32'hFFFF_FFFF);
    pulse_cycle_end();
    read_reg(A_CYCLE_CNT, v);
    check("cycle_cnt wrap", v, 32'h0);

    // TX FIFO order and status
    write_reg(A_TX_DATA, 32'h41);
    write_reg(A_TX_DATA, 32'h42);
    write_reg(A_TX_DATA, 32'h43);
    read_reg(A_TX_STATUS, v);
    check("status 3 queued", v, 32'h1);
    tx_ready = 1'b1;
    check("tx head 0", 32'(tx_data), 32'h41);
    tick();
    check("tx head 1", 32'(tx_data), 32'h42);
    tick();
    check("tx head 2", 32'(tx_data), 32'h43);
    tick();
    check("tx drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    read_reg(A_TX_STATUS, v);
    check("status empty", v, 32'h2);
    read_reg(A_TX_DATA, v);
    check("tx_data reads 0", v, 32'h0);

    // overflow
    for (int i = 0; i < 9; i++) write_reg(A_TX_DATA, 32'h50 + 32'(i));
    read_reg(A_TX_STATUS, v);
    check("status overflow", v, 32'hD);
    write_reg(A_TX_STATUS, 32'h0);
    read_reg(A_TX_STATUS, v);
    check("status ovf cleared", v, 32'h5);
    check("head after ovf", 32'(tx_data), 32'h50);
    tx_ready = 1'b1;
    repeat (9) tick();
    tx_ready = 1'b0;

    // faults
    read_reg(32'h4000_0000, v);
    check("unmapped rd data", v, 32'h0);
    check("unmapped err", 32'(err), 32'h1);
    read_reg(A_ERR_ADDR, v);
    check("err_addr first", v, 32'h4000_0000);
    read_reg(32'h4000_0004, v);
    read_reg(A_ERR_ADDR, v);
    check("err_addr kept", v, 32'h4000_0000);
    write_reg(A_ERR_ADDR, 32'h0);
    check("err cleared", 32'(err), 32'h0);
    read_reg(A_ERR_ADDR, v);
    check("err_addr cleared", v, 32'h0);

    // RAM boundary
    write_reg(32'(RAM_WORDS * 4 - 4), 32'hCAFE_F00D);
    read_reg(32'(RAM_WORDS * 4 - 4), v);
    check("ram last word", v, 32'hCAFE_F00D);
    read_reg(32'(RAM_WORDS * 4), v);
    check("ram end faults", 32'(err), 32'h1);
    write_reg(A_ERR_ADDR, 32'h0);

    // misaligned access
    read_reg(32'h12, v);
`ifdef DMEM_ALIGN_CHECK_EN
    check("misalign err", 32'(err), 32'h1);
    read_reg(A_ERR_ADDR, v);
    check("misalign err_addr", v, 32'h12);
    write_reg(A_ERR_ADDR, 32'h0);
`else
    check("misalign data", v, 32'hDEAD_BEEF);
    check("misalign no err", 32'(err), 32'h0);
`endif

    // same-cycle read and write of one word
    write_reg(32'h20, 32'h1111_1111);
    r_addr = 32'h20;
    r_en   = 1'b1;
    w_addr = 32'h20;
    w_data = 32'h2222_2222;
    w_en   = 1'b1;
    tick();
    check("read before write", r_data, 32'h1111_1111);
    tick();
    r_en = 1'b0;
    w_en = 1'b0;
    tick();
    read_reg(32'h20, v);
    check("write landed", v, 32'h2222_2222);

    // reset mid-operation: FIFO emptied, RAM untouched by the reset cycles
    write_reg(A_TX_DATA, 32'h61);
    write_reg(A_TX_DATA, 32'h62);
    rst_n  = 1'b0;
    w_addr = 32'h10;
    w_data = 32'h0BAD_F00D;
    w_en   = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    w_en  = 1'b0;
    check("mid reset tx_valid", 32'(tx_valid), 32'h0);
    check("mid reset r_data", r_data, 32'h0);
    tick();
    read_reg(32'h10, v);
    check("ram survives reset", v, 32'hDEAD_BEEF);
    read_reg(A_TX_STATUS, v);
    check("status after reset", v, 32'h2);

    // randomized traffic
    for (int t = 0; t < 600; t++) begin
      int hold;
      hold   = $urandom_range(2, 3);
      r_en   = 1'($urandom_range(0, 1));
      r_addr = rand_addr();
      w_en   = 1'($urandom_range(0, 1));
      w_addr = rand_addr();
      w_data = $urandom();
      for (int k = 0; k < hold; k++) begin
        tx_ready  = 1'($urandom_range(0, 1));
        cycle_end = ($urandom_range(0, 3) == 0);
        tick();
      end
      r_en      = 1'b0;
      w_en      = 1'b0;
      cycle_end = 1'b0;
      tx_ready  = 1'($urandom_range(0, 1));
      tick();
    end

    read_reg(A_CYCLE_CNT, v);
    check("final cycle_cnt", v, m_cnt);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
